// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - shared types, limits and BCD helpers for the wall clock
package clock_pkg;

    typedef logic [3:0] bcd_t;

    localparam logic [5:0] MAX_SEC      = 6'd59;
    localparam bcd_t       MAX_MIN_TENS = 4'd5;
    localparam logic [7:0] MAX_HOUR     = 8'h23;

    // 24 h BCD hour {tens, units} to 12 h BCD hour (00 -> 12, 13..23 -> 01..11)
    function automatic logic [7:0] to_12h(input logic [7:0] hour);
        logic [4:0] bin;
        logic [4:0] h12;
        bin = 5'(hour[7:4]) * 5'd10 + 5'(hour[3:0]);
        if (bin == 5'd0) begin
            h12 = 5'd12;
        end else if (bin > 5'd12) begin
            h12 = bin - 5'd12;
        end else begin
            h12 = bin;
        end
        if (h12 >= 5'd10) begin
            return {4'd1, 4'(h12 - 5'd10)};
        end
        return {4'd0, h12[3:0]};
    endfunction

    // {Ht, Hu, Mt, Mu} must be legal BCD, minutes tens <= 5, hour <= 23
    function automatic logic bcd_time_valid(input logic [15:0] t);
        return (t[15:12] <= 4'd9) && (t[11:8] <= 4'd9) &&
               (t[7:4] <= MAX_MIN_TENS) && (t[3:0] <= 4'd9) &&
               (t[15:8] <= MAX_HOUR);
    endfunction

    // BCD minutes +1 modulo 60
    function automatic logic [7:0] min_inc(input logic [7:0] m);
        if (m[3:0] == 4'd9) begin
            if (m[7:4] == MAX_MIN_TENS) begin
                return 8'h00;
            end
            return {m[7:4] + 4'd1, 4'd0};
        end
        return {m[7:4], m[3:0] + 4'd1};
    endfunction

    // BCD hours +1 modulo 24
    function automatic logic [7:0] hour_inc(input logic [7:0] h);
        if (h == MAX_HOUR) begin
            return 8'h00;
        end
        if (h[3:0] == 4'd9) begin
            return {h[7:4] + 4'd1, 4'd0};
        end
        return {h[7:4], h[3:0] + 4'd1};
    endfunction

endpackage

// File: rtl/bcd_timekeeper_if.sv
// rtl/bcd_timekeeper_if.sv - control, load, alarm and display signals of the timekeeper
interface bcd_timekeeper_if;
    logic        Enable;
    logic        Mode_12h;
    logic        Inc_Minutes;
    logic        Inc_Hours;
    logic        Load;
    logic [15:0] Load_Time;
    logic [15:0] Alarm_Time;
    logic        Alarm_Arm;
    logic        Alarm_Ack;
    logic [3:0]  Hours_Tens;
    logic [3:0]  Hours_Units;
    logic [3:0]  Minutes_Tens;
    logic [3:0]  Minutes_Units;
    logic [5:0]  Seconds;
    logic        PM;
    logic        Tick;
    logic        Alarm;
    logic        Load_Err;

    modport master (
        output Enable, Mode_12h, Inc_Minutes, Inc_Hours, Load, Load_Time,
               Alarm_Time, Alarm_Arm, Alarm_Ack,
        input  Hours_Tens, Hours_Units, Minutes_Tens, Minutes_Units,
               Seconds, PM, Tick, Alarm, Load_Err
    );

    modport slave (
        input  Enable, Mode_12h, Inc_Minutes, Inc_Hours, Load, Load_Time,
               Alarm_Time, Alarm_Arm, Alarm_Ack,
        output Hours_Tens, Hours_Units, Minutes_Tens, Minutes_Units,
               Seconds, PM, Tick, Alarm, Load_Err
    );
endinterface

// File: rtl/bcd_timekeeper_tick_prescaler.sv
// rtl/bcd_timekeeper_tick_prescaler.sv - one-second prescaler with clear
module tick_prescaler #(
    parameter int CLK_DIV = 100_000_000,
    parameter int DIV_W   = 27
) (
    input  logic Clk_100M,
    input  logic Reset_n,
    input  logic Enable,
    input  logic Clear,
    output logic Tick
);

    localparam logic [DIV_W-1:0] LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] count;

    // Tick marks the cycle whose closing edge wraps the count; the time
    // registers advance on that same edge and the top registers the pulse.
    assign Tick = Enable && !Clear && (count == LAST);

    // Count 0..CLK_DIV-1 while enabled; a valid load restarts the second
    always_ff @(posedge Clk_100M) begin
        if (!Reset_n) begin
            count <= '0;
        end else if (Clear) begin
            count <= '0;
        end else if (Enable) begin
            if (count == LAST) begin
                count <= '0;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/bcd_timekeeper.sv
// rtl/bcd_timekeeper.sv - 24 h BCD timekeeper with 12 h display, load and alarm
module bcd_timekeeper
    import clock_pkg::*;
#(
    parameter int CLK_DIV = 100_000_000,
    parameter int DIV_W   = 27
) (
    input  logic            Clk_100M,
    input  logic            Reset_n,
    bcd_timekeeper_if.slave bus
);

    logic [7:0] hour;
    logic [7:0] minute;
    logic [5:0] sec;
    logic       tick_q;
    logic       alarm_q;
    logic       load_err_q;

    logic [7:0] hour_n;
    logic [7:0] minute_n;
    logic [5:0] sec_n;
    logic       wrap;
    logic       load_ok;
    logic       tick_min;
    logic       tick_hour;
    logic       alarm_hit;
    logic [7:0] hour_disp;

    assign load_ok = bus.Load && bcd_time_valid(bus.Load_Time);

    tick_prescaler #(
        .CLK_DIV (CLK_DIV),
        .DIV_W   (DIV_W)
    ) u_prescaler (
        .Clk_100M (Clk_100M),
        .Reset_n  (Reset_n),
        .Enable   (bus.Enable),
        .Clear    (load_ok),
        .Tick     (wrap)
    );

    // Next time: load beats everything; an Inc overrides the tick carry into its field
    always_comb begin
        hour_n    = hour;
        minute_n  = minute;
        sec_n     = sec;
        tick_min  = 1'b0;
        tick_hour = 1'b0;
        if (load_ok) begin
            hour_n   = bus.Load_Time[15:8];
            minute_n = bus.Load_Time[7:0];
            sec_n    = 6'd0;
        end else begin
            if (wrap) begin
                if (sec == MAX_SEC) begin
                    sec_n    = 6'd0;
                    tick_min = 1'b1;
                end else begin
                    sec_n = sec + 6'd1;
                end
            end
            if (bus.Inc_Minutes) begin
                minute_n = min_inc(minute);
            end else if (tick_min) begin
                minute_n  = min_inc(minute);
                tick_hour = (minute == {MAX_MIN_TENS, 4'd9});
            end
            if (bus.Inc_Hours || tick_hour) begin
                hour_n = hour_inc(hour);
            end
        end
    end

    // Only a tick landing exactly on the alarm minute's :00 sets the alarm
    assign alarm_hit = wrap && bus.Alarm_Arm &&
                       ({hour_n, minute_n} == bus.Alarm_Time) && (sec_n == 6'd0);

    // Time, tick, alarm and load-error registers
    always_ff @(posedge Clk_100M) begin
        if (!Reset_n) begin
            hour       <= 8'h00;
            minute     <= 8'h00;
            sec        <= 6'd0;
            tick_q     <= 1'b0;
            alarm_q    <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            hour       <= hour_n;
            minute     <= minute_n;
            sec        <= sec_n;
            tick_q     <= wrap;
            load_err_q <= bus.Load && !load_ok;
            if (!bus.Alarm_Arm) begin
                alarm_q <= 1'b0;
            end else if (alarm_hit) begin
                alarm_q <= 1'b1;
            end else if (bus.Alarm_Ack) begin
                alarm_q <= 1'b0;
            end
        end
    end

    // Display digits follow the mode select without a register stage
    always_comb begin
        hour_disp = bus.Mode_12h ? to_12h(hour) : hour;
    end

    assign bus.Hours_Tens    = bcd_t'(hour_disp[7:4]);
    assign bus.Hours_Units   = bcd_t'(hour_disp[3:0]);
    assign bus.Minutes_Tens  = bcd_t'(minute[7:4]);
    assign bus.Minutes_Units = bcd_t'(minute[3:0]);
    assign bus.Seconds       = sec;
    assign bus.PM            = (hour >= 8'h12);
    assign bus.Tick          = tick_q;
    assign bus.Alarm         = alarm_q;
    assign bus.Load_Err      = load_err_q;

endmodule

// File: tb/tb_bcd_timekeeper.sv
// tb/tb_bcd_timekeeper.sv - directed and randomized check of bcd_timekeeper
module tb_bcd_timekeeper;

    localparam int CLK_DIV = 4;
    localparam int DIV_W   = 3;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    bcd_timekeeper_if bus ();

    bcd_timekeeper #(
        .CLK_DIV (CLK_DIV),
        .DIV_W   (DIV_W)
    ) dut (
        .Clk_100M (clk),
        .Reset_n  (rst_n),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference state: plain integers for hours, minutes, seconds, prescaler
    int mh, mm, ms, mpre;
    bit mtick, malarm, mlerr;

    function automatic bit time_ok(input logic [15:0] t);
        int ht, hu, mt, mu;
        ht = int'(t[15:12]);
        hu = int'(t[11:8]);
        mt = int'(t[7:4]);
        mu = int'(t[3:0]);
        return (ht <= 9) && (hu <= 9) && (mt <= 5) && (mu <= 9) && (ht * 10 + hu <= 23);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic model_edge();
        logic [15:0] lt;
        logic [15:0] at;
        bit lv, tk, cm, ch;
        int s0, m0, h0, ah, am;
        if (!rst_n) begin
            mh = 0; mm = 0; ms = 0; mpre = 0;
            mtick = 0; malarm = 0; mlerr = 0;
            return;
        end
        lt = bus.Load_Time;
        at = bus.Alarm_Time;
        lv = bus.Load && time_ok(lt);
        mlerr = bus.Load && !lv;
        tk = 0;
        if (lv) begin
            mh = int'(lt[15:12]) * 10 + int'(lt[11:8]);
            mm = int'(lt[7:4]) * 10 + int'(lt[3:0]);
            ms = 0;
            mpre = 0;
        end else begin
            if (bus.Enable) begin
                if (mpre == CLK_DIV - 1) begin
                    mpre = 0;
                    tk = 1;
                end else begin
                    mpre++;
                end
            end
            s0 = ms; m0 = mm; h0 = mh;
            cm = tk && (s0 == 59);
            if (tk) ms = (s0 + 1) % 60;
            if (bus.Inc_Minutes || cm) mm = (m0 + 1) % 60;
            ch = !bus.Inc_Minutes && cm && (m0 == 59);
            if (bus.Inc_Hours || ch) mh = (h0 + 1) % 24;
        end
        mtick = tk;
        ah = int'(at[15:12]) * 10 + int'(at[11:8]);
        am = int'(at[7:4]) * 10 + int'(at[3:0]);
        if (!bus.Alarm_Arm) malarm = 0;
        else if (tk && mh == ah && mm == am && ms == 0) malarm = 1;
        else if (bus.Alarm_Ack) malarm = 0;
    endtask

    task automatic check_all();
        int hd;
        hd = bus.Mode_12h ? ((mh % 12 == 0) ? 12 : mh % 12) : mh;
        chk("hours_tens", 32'(bus.Hours_Tens), hd / 10);
        chk("hours_units", 32'(bus.Hours_Units), hd % 10);
        chk("minutes_tens", 32'(bus.Minutes_Tens), mm / 10);
        chk("minutes_units", 32'(bus.Minutes_Units), mm % 10);
        chk("seconds", 32'(bus.Seconds), ms);
        chk("pm", 32'(bus.PM), (mh >= 12) ? 1 : 0);
        chk("tick", 32'(bus.Tick), 32'(mtick));
        chk("alarm", 32'(bus.Alarm), 32'(malarm));
        chk("load_err", 32'(bus.Load_Err), 32'(mlerr));
    endtask

    // one clock: model follows the inputs, DUT checked at the falling edge, pulses dropped
    task automatic step();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        check_all();
        bus.Load        = 1'b0;
        bus.Inc_Minutes = 1'b0;
        bus.Inc_Hours   = 1'b0;
        bus.Alarm_Ack   = 1'b0;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic chk_time(input string tag, input int h, input int m, input int s);
        chk({tag, "_ht"}, 32'(bus.Hours_Tens), h / 10);
        chk({tag, "_hu"}, 32'(bus.Hours_Units), h % 10);
        chk({tag, "_mt"}, 32'(bus.Minutes_Tens), m / 10);
        chk({tag, "_mu"}, 32'(bus.Minutes_Units), m % 10);
        chk({tag, "_sec"}, 32'(bus.Seconds), s);
    endtask

    initial begin
        logic [15:0] lt;
        int saved_sec;
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        bus.Enable = 1'b0; bus.Mode_12h = 1'b0;
        bus.Inc_Minutes = 1'b0; bus.Inc_Hours = 1'b0;
        bus.Load = 1'b0; bus.Load_Time = 16'h0000;
        bus.Alarm_Time = 16'h0000; bus.Alarm_Arm = 1'b0; bus.Alarm_Ack = 1'b0;
        @(negedge clk);
        steps(2);
        chk_time("reset", 0, 0, 0);

        // free run: tick on every 4th cycle
        rst_n = 1'b1;
        bus.Enable = 1'b1;
        steps(3);
        chk("tick_not_yet", 32'(bus.Tick), 0);
        step();
        chk("tick1", 32'(bus.Tick), 1);
        chk("tick1_sec", 32'(bus.Seconds), 1);
        steps(8);
        chk("tick3_sec", 32'(bus.Seconds), 3);
        chk_time("run", 0, 0, 3);

        // midnight rollover
        bus.Load = 1'b1; bus.Load_Time = 16'h2359;
        step();
        steps(60 * CLK_DIV);
        chk_time("midnight", 0, 0, 0);
        chk("midnight_pm", 32'(bus.PM), 0);
        chk("midnight_tick", 32'(bus.Tick), 1);

        // Inc_Minutes coincident with minute carry: hours stay
        bus.Load = 1'b1; bus.Load_Time = 16'h1059;
        step();
        steps(60 * CLK_DIV - 1);
        bus.Inc_Minutes = 1'b1;
        step();
        chk_time("inc_vs_carry", 10, 0, 0);

        // 12 h display
        bus.Mode_12h = 1'b1;
        bus.Load = 1'b1; bus.Load_Time = 16'h0030;
        step();
        chk_time("h12_0030", 12, 30, 0);
        chk("h12_0030_pm", 32'(bus.PM), 0);
        bus.Load = 1'b1; bus.Load_Time = 16'h1305;
        step();
        chk_time("h12_1305", 1, 5, 0);
        chk("h12_1305_pm", 32'(bus.PM), 1);
        bus.Load = 1'b1; bus.Load_Time = 16'h1200;
        step();
        chk_time("h12_1200", 12, 0, 0);
        chk("h12_1200_pm", 32'(bus.PM), 1);
        bus.Mode_12h = 1'b0;
        step();
        chk("h24_1200_ht", 32'(bus.Hours_Tens), 1);

        // alarm at 07:00:00
        bus.Alarm_Time = 16'h0700; bus.Alarm_Arm = 1'b1;
        bus.Load = 1'b1; bus.Load_Time = 16'h0659;
        step();
        steps(60 * CLK_DIV - 1);
        chk("alarm_before", 32'(bus.Alarm), 0);
        step();
        chk("alarm_set", 32'(bus.Alarm), 1);
        chk_time("alarm_time", 7, 0, 0);
        bus.Alarm_Ack = 1'b1;
        step();
        chk("alarm_ack", 32'(bus.Alarm), 0);
        bus.Alarm_Arm = 1'b0;
        bus.Alarm_Ack = 1'b1;
        step();
        chk("alarm_disarmed", 32'(bus.Alarm), 0);

        // invalid loads
        bus.Load = 1'b1; bus.Load_Time = 16'h2400;
        step();
        chk("err_2400", 32'(bus.Load_Err), 1);
        chk("err_2400_ht", 32'(bus.Hours_Tens), 0);
        chk("err_2400_hu", 32'(bus.Hours_Units), 7);
        step();
        chk("err_2400_clear", 32'(bus.Load_Err), 0);
        bus.Load = 1'b1; bus.Load_Time = 16'h0960;
        step();
        chk("err_0960", 32'(bus.Load_Err), 1);
        chk("err_0960_mt", 32'(bus.Minutes_Tens), 0);
        step();
        chk("err_0960_clear", 32'(bus.Load_Err), 0);

        // frozen time, hour wrap by Inc_Hours
        bus.Enable = 1'b0;
        bus.Load = 1'b1; bus.Load_Time = 16'h2300;
        step();
        saved_sec = int'(bus.Seconds);
        steps(10);
        chk("frozen_sec", 32'(bus.Seconds), saved_sec);
        chk("frozen_tick", 32'(bus.Tick), 0);
        bus.Inc_Hours = 1'b1;
        step();
        chk_time("inc_h_wrap", 0, 0, 0);
        bus.Enable = 1'b1;
        steps(7);
        chk("resume_sec", 32'(bus.Seconds), 1);

        // reset mid-run with the alarm set
        bus.Alarm_Arm = 1'b1; bus.Alarm_Time = 16'h0001;
        steps(60 * CLK_DIV);
        chk("pre_reset_alarm", 32'(bus.Alarm), 1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk_time("mid_reset", 0, 0, 0);
        chk("mid_reset_alarm", 32'(bus.Alarm), 0);

        // randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            rst_n           = ($urandom_range(0, 499) != 0);
            bus.Enable      = ($urandom_range(0, 9) != 0);
            bus.Mode_12h    = ($urandom_range(0, 19) == 0) ? ~bus.Mode_12h : bus.Mode_12h;
            bus.Inc_Minutes = ($urandom_range(0, 29) == 0);
            bus.Inc_Hours   = ($urandom_range(0, 39) == 0);
            bus.Alarm_Ack   = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 99) == 0) bus.Alarm_Arm = ~bus.Alarm_Arm;
            if ($urandom_range(0, 59) == 0) begin
                lt[15:12] = 4'($urandom_range(0, 3));
                lt[11:8]  = 4'($urandom_range(0, 10));
                lt[7:4]   = 4'($urandom_range(0, 6));
                lt[3:0]   = 4'($urandom_range(0, 10));
                bus.Load_Time = lt;
                bus.Load = 1'b1;
            end
            if ($urandom_range(0, 149) == 0) begin
                lt[15:12] = 4'(mh / 10);
                lt[11:8]  = 4'(mh % 10);
                lt[7:4]   = 4'(((mm + 1) % 60) / 10);
                lt[3:0]   = 4'(((mm + 1) % 60) % 10);
                bus.Alarm_Time = lt;
            end
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bcd_timekeeper.md
# bcd_timekeeper

Parametrised successor of the board's 24-hour wall clock. It keeps hh:mm:ss time from a configurable prescaler and supports 12/24-hour display mode, parallel BCD load, pause, and a single armed alarm with acknowledge. It sits between the debounced button inputs and the seven-segment driver, replacing the fixed-rate clock counter.

## Interface

Parameters:
- CLK_DIV, 100_000_000, clock cycles per one-second Tick (≥2)
- DIV_W, 27, prescaler width; must satisfy 2^DIV_W ≥ CLK_DIV

Ports:
- Clk_100M  in  1  system clock
- Reset_n  in  1  synchronous, active-low reset
- Enable  in  1  1 = time runs; 0 = prescaler and time frozen
- Mode_12h  in  1  display select: 0 = 24 h, 1 = 12 h
- Inc_Minutes  in  1  single-cycle pulse (debounced): minutes +1
- Inc_Hours  in  1  single-cycle pulse (debounced): hours +1
- Load  in  1  single-cycle pulse: load Load_Time
- Load_Time  in  16  BCD {Ht, Hu, Mt, Mu}, 24 h
- Alarm_Time  in  16  BCD {Ht, Hu, Mt, Mu}, 24 h
- Alarm_Arm  in  1  level: alarm enabled
- Alarm_Ack  in  1  single-cycle pulse: clear Alarm
- Hours_Tens, Hours_Units, Minutes_Tens, Minutes_Units  out  4 each  display BCD digits
- Seconds  out  6  binary seconds 0–59 (drives LEDs)
- PM  out  1  1 when internal hour ≥ 12 (valid in both modes)
- Tick  out  1  one-cycle pulse per second
- Alarm  out  1  latched alarm flag
- Load_Err  out  1  one-cycle pulse: invalid Load rejected

## Operation

- Internal state is always 24 h BCD (hours 00–23, minutes 00–59) plus binary seconds 0–59 and prescaler count 0..CLK_DIV-1.
- Reset (Reset_n = 0 at a rising edge): time 00:00:00, prescaler 0, Alarm 0, Tick 0, Load_Err 0. Reset overrides every other input.
- Prescaler: when Enable = 1 it increments each cycle; at CLK_DIV-1 it wraps to 0 and Tick asserts for that cycle. The period is exactly CLK_DIV cycles. When Enable = 0 the prescaler holds.
- On Tick: seconds +1. At 59 seconds wrap to 0 and carry into minutes. Minutes carry at 59 into hours. 23:59:59 → 00:00:00.
- Inc_Minutes: minutes +1 modulo 60, no carry into hours, seconds unchanged. Inc_Hours: hours +1 modulo 24. Both work while Enable = 0.
- Load: if Load_Time is valid (each digit ≤ 9, Mt ≤ 5, hours ≤ 23), time := Load_Time with seconds 0 and prescaler 0. Otherwise state is unchanged and Load_Err pulses.
- Priority per cycle: Reset > Load > Inc / Tick. When an Inc and a Tick carry target the same field in the same cycle, the Inc result wins and that carry is dropped. Seconds still update from the Tick.
- 12 h display: internal hour 00 → 12; 01–12 → unchanged; 13–23 → hour − 12. The display is combinational from state, so a Mode_12h change is visible the same cycle.
- Alarm: sets when Alarm_Arm = 1 and a Tick moves the time to Alarm_Time:00. Load and Inc never trigger it. It stays set until Alarm_Ack or Alarm_Arm = 0. If set and ack occur in the same cycle, set wins.

## Timing

- All state and outputs are registered except the display digits and PM, which are combinational from the registered state.
- Tick, time update and Alarm assertion happen on the same clock edge: Tick is high in the cycle where the new time first appears.
- Load or Inc takes effect at the next edge (1-cycle latency). Load_Err is high in the cycle after the rejected Load.
- Reset_n low mid-count: outputs are zero after the next edge.

## Structure

- Package clock_pkg contains:
  - bcd_t (4-bit digit typedef)
  - constants MAX_SEC = 59, MAX_MIN_TENS = 5, MAX_HOUR = 23
  - function to_12h (24 h BCD hour → 12 h BCD hour)
  - function bcd_time_valid
- Sub-module tick_prescaler (CLK_DIV, DIV_W; ports Clk_100M, Reset_n, Enable, Clear, Tick). Clear is driven by Load.

## Test plan

- CLK_DIV = 4, reset released, Enable = 1 → Tick every 4th cycle; Seconds reads 1, 2, 3 after ticks 1–3; digits read 00:00.
- Load 16'h2359, 60 Ticks → 00:00, Seconds 0, PM 0. Load 16'h1059, Inc_Minutes coincident with the 60th Tick → 10:00:00 (hours stay 10).
- Mode_12h = 1: Load 0030 → 12:30, PM 0. Load 1305 → 01:05, PM 1. Load 1200 → 12:00, PM 1.
- Alarm_Time 0700, Arm = 1, Load 0659, 60 Ticks → Alarm = 1 in the same cycle the time becomes 07:00:00. Ack → 0. Ack while Arm = 0 → stays 0.
- Load 16'h2400 and 16'h0960 → state unchanged, Load_Err pulses once each.
- Enable = 0 for 10 cycles → Seconds and prescaler frozen; Inc_Hours at hour 23 → 00. Reset_n low for 1 cycle mid-run → 00:00:00, Alarm 0.
